seg_scan_decode: RTL and testbench

Passive monitor that reads a multiplexed 6-digit, common-anode seven-segment bus (digit select plus segment lines, both active-low) and recovers the six displayed ASCII characters. It is the receive end of the scanned ASCII display path. It is used to self-check display output on-board, or to snoop an external display. It captures each digit only after its lines settle, decodes the segment pattern back to ASCII, and signals each completed 6-digit frame.

---
 rtl/seg_scan_decode.sv | 245 ++++++++++++++++++++++++
 tb/tb_seg_scan_decode.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decode.sv
// Passive receiver for a scanned 6-digit common-anode seven-segment bus; recovers ASCII per digit.
// Optional feature macro: SEG_SCAN_DECODE_DP_EN (decimal point reported on dp instead of flagged as error).
module seg_scan_decode #(
  parameter int SETTLE    = 8,
  parameter int BLANK_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] seg_sel,
  input  logic [7:0] seg_led,
  output logic [7:0] char0,
  output logic [7:0] char1,
  output logic [7:0] char2,
  output logic [7:0] char3,
  output logic [7:0] char4,
  output logic [7:0] char5,
  output logic [5:0] dp,
  output logic       frame_stb,
  output logic       blank,
  output logic       err_stb
);

  localparam int STAB_W = $clog2(SETTLE + 1);
  localparam int BLNK_W = $clog2(BLANK_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE);
  localparam logic [BLNK_W-1:0] BLNK_MAX = BLNK_W'(BLANK_CYC);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLING,
    ST_CAPTURE,
    ST_HELD
  } state_t;

  logic [13:0]       meta_q, meta_d;
  logic [13:0]       sync_q, sync_d;
  logic [13:0]       prev_q, prev_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [BLNK_W-1:0] blnk_q, blnk_d;
  state_t            state_q, state_d;
  logic [7:0]        char_q [6];
  logic [7:0]        char_d [6];
  logic [5:0]        dp_q, dp_d;
  logic [5:0]        mask_q, mask_d;
  logic              frame_q, frame_d;
  logic              err_q, err_d;
  logic              blank_q, blank_d;

  logic [5:0] sel_s;
  logic [5:0] sel_hot;
  logic [7:0] led_s;
  logic [5:0] mask_set;
  logic       sel_valid;
  logic       sel_idle;
  logic       bus_changed;
  logic       settle_done;
  logic       capture_go;
  logic       blank_hit;
  logic [6:0] pat;
  logic [7:0] dec_char;
  logic       dec_err;
  logic       dec_dp;

  // Both buses are asynchronous to clk; they share one 2-stage synchroniser chain.
  always_comb begin
    meta_d = {seg_sel, seg_led};
    sync_d = meta_q;
    prev_d = sync_q;
  end

  assign sel_s       = sync_q[13:8];
  assign led_s       = sync_q[7:0];
  assign sel_hot     = ~sel_s;
  assign sel_valid   = $onehot(sel_hot);
  assign sel_idle    = (sel_s == 6'h3F);
  assign bus_changed = (sync_q != prev_q);
  // The extra !bus_changed keeps a change landing in the capture cycle from being latched.
  assign settle_done = sel_valid && !bus_changed && (stab_q == STAB_MAX);

  always_comb begin
    stab_d = stab_q;
    if (bus_changed) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end
  end

  // Idle counter: runs on all-high select, clears on a single selected digit, holds on multi-low.
  always_comb begin
    blnk_d = blnk_q;
    if (sel_idle) begin
      if (blnk_q != BLNK_MAX) begin
        blnk_d = blnk_q + BLNK_W'(1);
      end
    end else if (sel_valid) begin
      blnk_d = '0;
    end
    blank_hit = sel_idle && (blnk_d == BLNK_MAX);
    blank_d   = sel_idle && (blank_q || blank_hit);
  end

  always_comb begin
    pat      = ~led_s[6:0];
    dec_char = 8'h3F;
    dec_err  = 1'b0;
    dec_dp   = 1'b0;
    case (pat)
      7'h00:   dec_char = 8'h00;
      7'h3F:   dec_char = 8'h30;
      7'h06:   dec_char = 8'h31;
      7'h5B:   dec_char = 8'h32;
      7'h4F:   dec_char = 8'h33;
      7'h66:   dec_char = 8'h34;
      7'h6D:   dec_char = 8'h35;
      7'h7D:   dec_char = 8'h36;
      7'h07:   dec_char = 8'h37;
      7'h7F:   dec_char = 8'h38;
      7'h6F:   dec_char = 8'h39;
      7'h71:   dec_char = 8'h46;
      default: dec_err  = 1'b1;
    endcase
`ifdef SEG_SCAN_DECODE_DP_EN
    dec_dp = ~led_s[7];
`else
    if (!led_s[7]) begin
      dec_char = 8'h3F;
      dec_err  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (sel_valid) state_d = ST_SETTLING;
      end
      ST_SETTLING: begin
        if (!sel_valid)       state_d = ST_WAIT;
        else if (settle_done) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!sel_valid)       state_d = ST_WAIT;
        else if (bus_changed) state_d = ST_SETTLING;
        else                  state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!sel_valid)       state_d = ST_WAIT;
        else if (bus_changed) state_d = ST_SETTLING;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Capture is registered on the edge that enters CAPTURE, so results show during that state.
  always_comb begin
    capture_go = (state_q == ST_SETTLING) && settle_done;
  end

  always_comb begin
    char_d   = char_q;
    dp_d     = dp_q;
    mask_d   = mask_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    mask_set = mask_q | sel_hot;
    if (blank_hit) begin
      for (int i = 0; i < 6; i++) begin
        char_d[i] = 8'h00;
      end
      dp_d   = '0;
      mask_d = '0;
    end else if (capture_go) begin
      for (int i = 0; i < 6; i++) begin
        if (sel_hot[i]) begin
          char_d[i] = dec_char;
          dp_d[i]   = dec_dp;
        end
      end
      if ((mask_q & sel_hot) != 6'h00) begin
        mask_d = sel_hot;
        err_d  = 1'b1;
      end else if (mask_set == 6'h3F) begin
        mask_d  = '0;
        frame_d = 1'b1;
      end else begin
        mask_d = mask_set;
      end
      if (dec_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= '1;
      sync_q  <= '1;
      prev_q  <= '1;
      stab_q  <= '0;
      blnk_q  <= '0;
      dp_q    <= '0;
      mask_q  <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        char_q[i] <= 8'h00;
      end
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      blnk_q  <= blnk_d;
      dp_q    <= dp_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      for (int i = 0; i < 6; i++) begin
        char_q[i] <= char_d[i];
      end
    end
  end

  assign char0     = char_q[0];
  assign char1     = char_q[1];
  assign char2     = char_q[2];
  assign char3     = char_q[3];
  assign char4     = char_q[4];
  assign char5     = char_q[5];
  assign dp        = dp_q;
  assign frame_stb = frame_q;
  assign err_stb   = err_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_seg_scan_decode.sv
// Self-checking bench for seg_scan_decode: directed scenarios plus a randomized scan against a
// character-level model of the display (decode table, per-frame digit set, idle blanking).
module tb_seg_scan_decode;

  localparam int SETTLE    = 8;
  localparam int BLANK_CYC = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;
  logic [7:0] char0, char1, char2, char3, char4, char5;
  logic [5:0] dp;
  logic       frame_stb, blank, err_stb;

  always #5 clk = ~clk;

  seg_scan_decode #(.SETTLE(SETTLE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_sel(seg_sel), .seg_led(seg_led),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3), .char4(char4), .char5(char5),
    .dp(dp), .frame_stb(frame_stb), .blank(blank), .err_stb(err_stb)
  );

  logic [7:0] dut_char [6];
  assign dut_char[0] = char0;
  assign dut_char[1] = char1;
  assign dut_char[2] = char2;
  assign dut_char[3] = char3;
  assign dut_char[4] = char4;
  assign dut_char[5] = char5;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the display shows, and which digits the current frame has seen.
  logic [7:0] m_char [6];
  logic [5:0] m_dp;
  bit         seen [6];
  logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] pats123 [6]    = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};

  function automatic logic [5:0] sel_of(input int k);
    logic [5:0] one;
    one = 6'b000001 << k;
    return ~one;
  endfunction

  function automatic void model_decode(input logic [7:0] seg, output logic [7:0] ch,
                                       output bit err, output bit dpl);
    logic [7:0] lit;
    lit = ~seg;
    ch  = 8'h3F;
    err = 1'b1;
    dpl = 1'b0;
    if (lit[6:0] == 7'h00) begin
      ch = 8'h00; err = 1'b0;
    end else if (lit[6:0] == 7'h71) begin
      ch = "F"; err = 1'b0;
    end else begin
      for (int d = 0; d < 10; d++) begin
        if (lit[6:0] == digit_pat[d]) begin
          ch = 8'(8'h30 + d); err = 1'b0;
        end
      end
    end
`ifdef SEG_SCAN_DECODE_DP_EN
    dpl = lit[7];
`else
    if (lit[7]) begin
      ch = 8'h3F; err = 1'b1;
    end
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_char[i] = 8'h00;
      seen[i]   = 1'b0;
    end
    m_dp = 6'h00;
  endtask

  task automatic model_capture(input int k, input logic [7:0] seg, output bit exp_err, output bit exp_frame);
    logic [7:0] ch;
    bit derr, dpl, full;
    model_decode(seg, ch, derr, dpl);
    m_char[k] = ch;
    m_dp[k]   = dpl;
    exp_err   = derr;
    exp_frame = 1'b0;
    if (seen[k]) begin
      for (int i = 0; i < 6; i++) seen[i] = 1'b0;
      seen[k] = 1'b1;
      exp_err = 1'b1;
    end else begin
      seen[k] = 1'b1;
      full = 1'b1;
      for (int i = 0; i < 6; i++) if (!seen[i]) full = 1'b0;
      if (full) begin
        exp_frame = 1'b1;
        for (int i = 0; i < 6; i++) seen[i] = 1'b0;
      end
    end
  endtask

  // Drives one bus value for 'hold' cycles (from a falling edge), counting strobes seen.
  task automatic show(input logic [5:0] sel, input logic [7:0] seg, input int hold,
                      input int watch_k, input logic [7:0] watch_v,
                      output int nf, output int ne, output bit hit);
    seg_sel = sel;
    seg_led = seg;
    nf = 0; ne = 0; hit = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (frame_stb) nf++;
      if (err_stb) ne++;
      if (watch_k >= 0) begin
        if (dut_char[watch_k] === watch_v) hit = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    seg_sel = 6'h3F;
    seg_led = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    seg_sel = 6'h3F;
    seg_led = 8'hFF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (dut_char[i] !== 8'h00) begin n_fail++; $display("FAIL reset_char%0d got %h want 00", i, dut_char[i]); end
    end
    n_checks++;
    if (dp !== 6'h00) begin n_fail++; $display("FAIL reset_dp got %h want 00", dp); end
    n_checks++;
    if ({frame_stb, err_stb, blank} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000", {frame_stb, err_stb, blank});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({frame_stb, err_stb, blank, char0} !== 11'h000) begin
      n_fail++; $display("FAIL reset_release got %h want 000", {frame_stb, err_stb, blank, char0});
    end
    model_clear();
  endtask

  task automatic test_latency();
    bit xe, xf;
    seg_sel = sel_of(0);
    seg_led = 8'hF9;
    for (int j = 1; j <= SETTLE + 4; j++) begin
      @(negedge clk);
      if (j == SETTLE + 3) begin
        n_checks++;
        if (char0 !== 8'h00) begin n_fail++; $display("FAIL latency_early got %h want 00", char0); end
      end
      if (j == SETTLE + 4) begin
        n_checks++;
        if (char0 !== 8'h31) begin n_fail++; $display("FAIL latency_capture got %h want 31", char0); end
      end
    end
    model_capture(0, 8'hF9, xe, xf);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_steady_scan();
    int nf, ne;
    bit hit, xe, xf;
    logic [7:0] want;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 6; k++) begin
        show(sel_of(k), pats123[k], 40, -1, 8'h00, nf, ne, hit);
        model_capture(k, pats123[k], xe, xf);
        n_checks++;
        if (dut_char[k] !== m_char[k]) begin n_fail++; $display("FAIL steady_char%0d got %h want %h", k, dut_char[k], m_char[k]); end
        n_checks++;
        if (ne !== int'(xe)) begin n_fail++; $display("FAIL steady_err%0d got %0d want %0d", k, ne, xe); end
        n_checks++;
        if (nf !== int'(xf)) begin n_fail++; $display("FAIL steady_frame%0d got %0d want %0d", k, nf, xf); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      want = 8'(8'h31 + k);
      n_checks++;
      if (dut_char[k] !== want) begin n_fail++; $display("FAIL steady_text%0d got %h want %h", k, dut_char[k], want); end
    end
  endtask

  task automatic test_glitch();
    int nf1, ne1, nf2, ne2;
    bit hit1, hit2, xe, xf;
    show(sel_of(2), 8'hF9, SETTLE - 1, 2, 8'h31, nf1, ne1, hit1);
    show(sel_of(2), 8'hA4, 40, 2, 8'h31, nf2, ne2, hit2);
    model_capture(2, 8'hA4, xe, xf);
    n_checks++;
    if (char2 !== 8'h32) begin n_fail++; $display("FAIL glitch_char2 got %h want 32", char2); end
    n_checks++;
    if ((hit1 | hit2) !== 1'b0) begin n_fail++; $display("FAIL glitch_intermediate got 1 want 0"); end
    n_checks++;
    if ((ne1 + ne2) !== int'(xe)) begin n_fail++; $display("FAIL glitch_err got %0d want %0d", ne1 + ne2, xe); end
  endtask

  task automatic test_unknown();
    int ks [3] = '{0, 1, 3};
    logic [7:0] segs [3] = '{8'hFF, 8'h8E, 8'h55};
    int nf, ne;
    bit hit, xe, xf;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      show(sel_of(ks[t]), segs[t], 40, -1, 8'h00, nf, ne, hit);
      model_capture(ks[t], segs[t], xe, xf);
      n_checks++;
      if (dut_char[ks[t]] !== m_char[ks[t]]) begin
        n_fail++; $display("FAIL unknown_char%0d got %h want %h", ks[t], dut_char[ks[t]], m_char[ks[t]]);
      end
      n_checks++;
      if (ne !== int'(xe)) begin n_fail++; $display("FAIL unknown_err%0d got %0d want %0d", ks[t], ne, xe); end
    end
    n_checks++;
    if ({char0, char1, char3} !== 24'h00_46_3F) begin
      n_fail++; $display("FAIL unknown_text got %h want 00463f", {char0, char1, char3});
    end
  endtask

  task automatic test_order();
    int seq [9] = '{0, 1, 2, 1, 2, 3, 4, 5, 0};
    int nf, ne;
    bit hit, xe, xf;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      show(sel_of(seq[t]), pats123[seq[t]], 30, -1, 8'h00, nf, ne, hit);
      model_capture(seq[t], pats123[seq[t]], xe, xf);
      n_checks++;
      if (ne !== int'(xe)) begin n_fail++; $display("FAIL order_err step%0d got %0d want %0d", t, ne, xe); end
      n_checks++;
      if (nf !== int'(xf)) begin n_fail++; $display("FAIL order_frame step%0d got %0d want %0d", t, nf, xf); end
    end
  endtask

  task automatic test_random();
    int k, prev_k, nf, ne, d;
    logic [7:0] seg, prev_seg;
    bit hit, xe, xf;
    do_reset();
    prev_k   = -1;
    prev_seg = 8'h00;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 7) k = (prev_k + 1) % 6;
      else k = int'($urandom_range(0, 5));
      do begin
        case ($urandom_range(0, 3))
          0: begin
            d = int'($urandom_range(0, 9));
            seg = {1'b1, ~digit_pat[d]};
`ifdef SEG_SCAN_DECODE_DP_EN
            seg[7] = 1'($urandom_range(0, 1));
`endif
          end
          1:       seg = 8'($urandom);
          2:       seg = 8'hFF;
          default: seg = 8'h8E;
        endcase
      end while (k == prev_k && seg == prev_seg);
      show(sel_of(k), seg, int'($urandom_range(20, 40)), -1, 8'h00, nf, ne, hit);
      model_capture(k, seg, xe, xf);
      n_checks++;
      if (dut_char[k] !== m_char[k]) begin n_fail++; $display("FAIL rand_char t%0d d%0d seg %h got %h want %h", t, k, seg, dut_char[k], m_char[k]); end
      n_checks++;
      if (dp !== m_dp) begin n_fail++; $display("FAIL rand_dp t%0d got %h want %h", t, dp, m_dp); end
      n_checks++;
      if (ne !== int'(xe)) begin n_fail++; $display("FAIL rand_err t%0d got %0d want %0d", t, ne, xe); end
      n_checks++;
      if (nf !== int'(xf)) begin n_fail++; $display("FAIL rand_frame t%0d got %0d want %0d", t, nf, xf); end
      prev_k   = k;
      prev_seg = seg;
    end
  endtask

  task automatic test_idle();
    int nf, ne;
    bit xe, xf;
    seg_sel = 6'h3F;
    seg_led = 8'hFF;
    for (int j = 1; j <= BLANK_CYC + 2; j++) begin
      @(negedge clk);
      if (j == BLANK_CYC + 1) begin
        n_checks++;
        if (blank !== 1'b0) begin n_fail++; $display("FAIL idle_early got %b want 0", blank); end
      end
      if (j == BLANK_CYC + 2) begin
        n_checks++;
        if (blank !== 1'b1) begin n_fail++; $display("FAIL idle_blank got %b want 1", blank); end
      end
    end
    model_clear();
    n_checks++;
    if ({char0, char1, char2, char3, char4, char5} !== 48'h0) begin
      n_fail++; $display("FAIL idle_chars got %h want 0", {char0, char1, char2, char3, char4, char5});
    end
    n_checks++;
    if (dp !== 6'h00) begin n_fail++; $display("FAIL idle_dp got %h want 00", dp); end
    seg_sel = sel_of(4);
    seg_led = 8'h40;
    nf = 0; ne = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (frame_stb) nf++;
      if (err_stb) ne++;
      if (j == 2) begin
        n_checks++;
        if (blank !== 1'b1) begin n_fail++; $display("FAIL wake_hold got %b want 1", blank); end
      end
      if (j == 3) begin
        n_checks++;
        if (blank !== 1'b0) begin n_fail++; $display("FAIL wake_fall got %b want 0", blank); end
      end
    end
    model_capture(4, 8'h40, xe, xf);
    n_checks++;
    if (char4 !== m_char[4]) begin n_fail++; $display("FAIL dp_char4 got %h want %h", char4, m_char[4]); end
    n_checks++;
    if (dp !== m_dp) begin n_fail++; $display("FAIL dp_bits got %h want %h", dp, m_dp); end
    n_checks++;
    if (ne !== int'(xe)) begin n_fail++; $display("FAIL dp_err got %0d want %0d", ne, xe); end
  endtask

  task automatic test_multi_low();
    int nf, ne;
    bit hit;
    show(6'b111100, 8'hF9, 40, -1, 8'h00, nf, ne, hit);
    n_checks++;
    if ((nf + ne) !== 0) begin n_fail++; $display("FAIL multi_strobes got %0d want 0", nf + ne); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (dut_char[i] !== m_char[i]) begin n_fail++; $display("FAIL multi_char%0d got %h want %h", i, dut_char[i], m_char[i]); end
    end
    n_checks++;
    if (blank !== 1'b0) begin n_fail++; $display("FAIL multi_blank got %b want 0", blank); end
  endtask

  task automatic test_reset_mid_frame();
    int seq [6] = '{3, 4, 5, 0, 1, 2};
    int nf, ne;
    bit hit, xe, xf;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      show(sel_of(k), pats123[k], 40, -1, 8'h00, nf, ne, hit);
      model_capture(k, pats123[k], xe, xf);
    end
    n_checks++;
    if ({char0, char1, char2} !== 24'h31_32_33) begin
      n_fail++; $display("FAIL midrst_pre got %h want 313233", {char0, char1, char2});
    end
    rst_n   = 1'b0;
    seg_sel = 6'h3F;
    seg_led = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({char0, char1, char2, char3, char4, char5} !== 48'h0) begin
        n_fail++; $display("FAIL midrst_low cyc%0d got %h want 0", c, {char0, char1, char2, char3, char4, char5});
      end
    end
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      show(sel_of(seq[t]), pats123[seq[t]], 40, -1, 8'h00, nf, ne, hit);
      model_capture(seq[t], pats123[seq[t]], xe, xf);
      n_checks++;
      if (nf !== int'(xf)) begin n_fail++; $display("FAIL midrst_frame step%0d got %0d want %0d", t, nf, xf); end
      n_checks++;
      if (ne !== int'(xe)) begin n_fail++; $display("FAIL midrst_err step%0d got %0d want %0d", t, ne, xe); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_sel = 6'h3F;
    seg_led = 8'hFF;
    test_reset();
    test_latency();
    test_steady_scan();
    test_glitch();
    test_unknown();
    test_order();
    test_random();
    test_idle();
    test_multi_low();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
